// File: rtl/clock_reset_sequencer.sv
// Lock supervisor and staggered reset-release sequencer for the board clock tree.
// Runs from the free-running reference clock; pulses the PLL reset, qualifies locks, then releases domains in order.
module clock_reset_sequencer #(
    parameter int N_LOCK        = 2,
    parameter int N_DOMAIN      = 3,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGGER       = 8,
    parameter int MAX_RETRY     = 7,
    parameter int CW            = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                restart,
    input  logic [N_LOCK-1:0]   lock_in,
    output logic [N_LOCK-1:0]   lock_sync,
    output logic                pll_rst,
    output logic [N_DOMAIN-1:0] domain_rst,
    output logic                ready,
    output logic                fault,
    output logic [7:0]          retry_cnt
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_e;

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST     = CW'((N_DOMAIN - 1) * STAGGER);
    localparam logic [7:0]    RETRY_LIMIT  = 8'(MAX_RETRY);

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [N_LOCK-1:0]   sync1_q;
    logic [N_LOCK-1:0]   sync2_q;
    logic                pll_rst_q;
    logic [N_DOMAIN-1:0] dom_rst_q;
    logic                ready_q;
    logic                fault_q;
    logic [7:0]          retry_q;

    logic [CW-1:0]       cnt_inc_d;
    logic                lock_all_s;

    // Bit k stays in reset until the release counter has reached k*STAGGER.
    function automatic logic [N_DOMAIN-1:0] release_mask(input logic [CW-1:0] rel_cnt);
        logic [N_DOMAIN-1:0] mask;
        mask = {N_DOMAIN{1'b1}};
        for (int k = 0; k < N_DOMAIN; k++) begin
            if (CW'(k * STAGGER) <= rel_cnt) begin
                mask[k] = 1'b0;
            end else begin
                mask[k] = 1'b1;
            end
        end
        return mask;
    endfunction

    // Shared counter increment and lock qualification.
    always_comb begin
        cnt_inc_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        lock_all_s = &sync2_q;
    end

    // Two-flop synchroniser for the asynchronous lock indicators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= {N_LOCK{1'b0}};
            sync2_q <= {N_LOCK{1'b0}};
        end else begin
            sync1_q <= lock_in;
            sync2_q <= sync1_q;
        end
    end

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= {CW{1'b0}};
            pll_rst_q <= 1'b1;
            dom_rst_q <= {N_DOMAIN{1'b1}};
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            retry_q   <= 8'd0;
        end else if (restart) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= {CW{1'b0}};
            pll_rst_q <= 1'b1;
            dom_rst_q <= {N_DOMAIN{1'b1}};
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            retry_q   <= 8'd0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    pll_rst_q <= 1'b1;
                    dom_rst_q <= {N_DOMAIN{1'b1}};
                    ready_q   <= 1'b0;
                    if (cnt_q == RST_LAST) begin
                        cnt_q     <= {CW{1'b0}};
                        pll_rst_q <= 1'b0;
                        state_q   <= S_WAIT_LOCK;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_all_s) begin
                        cnt_q   <= {CW{1'b0}};
                        state_q <= S_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_q     <= {CW{1'b0}};
                        pll_rst_q <= 1'b1;
                        if (retry_q == RETRY_LIMIT) begin
                            fault_q <= 1'b1;
                            state_q <= S_FAULT;
                        end else begin
                            retry_q <= retry_q + 8'd1;
                            state_q <= S_RESET_PLL;
                        end
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                S_STABLE: begin
                    if (!lock_all_s) begin
                        cnt_q   <= {CW{1'b0}};
                        state_q <= S_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        cnt_q     <= {CW{1'b0}};
                        dom_rst_q <= release_mask({CW{1'b0}});
                        // A single domain is fully released on the first release edge.
                        if (REL_LAST == {CW{1'b0}}) begin
                            ready_q <= 1'b1;
                            retry_q <= 8'd0;
                            state_q <= S_RUN;
                        end else begin
                            state_q <= S_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                S_RELEASE: begin
                    if (!lock_all_s) begin
                        cnt_q     <= {CW{1'b0}};
                        pll_rst_q <= 1'b1;
                        dom_rst_q <= {N_DOMAIN{1'b1}};
                        ready_q   <= 1'b0;
                        state_q   <= S_RESET_PLL;
                    end else begin
                        cnt_q     <= cnt_inc_d;
                        dom_rst_q <= release_mask(cnt_inc_d);
                        if (cnt_inc_d == REL_LAST) begin
                            ready_q <= 1'b1;
                            retry_q <= 8'd0;
                            state_q <= S_RUN;
                        end else begin
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (!lock_all_s) begin
                        cnt_q     <= {CW{1'b0}};
                        pll_rst_q <= 1'b1;
                        dom_rst_q <= {N_DOMAIN{1'b1}};
                        ready_q   <= 1'b0;
                        state_q   <= S_RESET_PLL;
                    end else begin
                        dom_rst_q <= {N_DOMAIN{1'b0}};
                        ready_q   <= 1'b1;
                        retry_q   <= 8'd0;
                    end
                end
                S_FAULT: begin
                    pll_rst_q <= 1'b1;
                    dom_rst_q <= {N_DOMAIN{1'b1}};
                    ready_q   <= 1'b0;
                    fault_q   <= 1'b1;
                end
                default: begin
                    state_q   <= S_RESET_PLL;
                    cnt_q     <= {CW{1'b0}};
                    pll_rst_q <= 1'b1;
                    dom_rst_q <= {N_DOMAIN{1'b1}};
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign lock_sync  = sync2_q;
    assign pll_rst    = pll_rst_q;
    assign domain_rst = dom_rst_q;
    assign ready      = ready_q;
    assign fault      = fault_q;
    assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed scoreboard bench for clock_reset_sequencer with small cycle-count parameters.
module tb_clock_reset_sequencer;

    localparam int SEL_PLL   = 0;
    localparam int SEL_DOM   = 1;
    localparam int SEL_READY = 2;
    localparam int SEL_FAULT = 3;
    localparam int SEL_RETRY = 4;
    localparam int SEL_LSYNC = 5;
    localparam int BOUND     = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       restart;
    logic [1:0] lock_in;
    logic [1:0] lock_sync;
    logic       pll_rst;
    logic [2:0] domain_rst;
    logic       ready;
    logic       fault;
    logic [7:0] retry_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    clock_reset_sequencer #(
        .N_LOCK(2), .N_DOMAIN(3), .RST_CYCLES(4), .LOCK_TIMEOUT(32),
        .STABLE_CYCLES(8), .STAGGER(2), .MAX_RETRY(2), .CW(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .lock_in(lock_in),
        .lock_sync(lock_sync), .pll_rst(pll_rst), .domain_rst(domain_rst),
        .ready(ready), .fault(fault), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            SEL_PLL:   return {31'd0, pll_rst};
            SEL_DOM:   return {29'd0, domain_rst};
            SEL_READY: return {31'd0, ready};
            SEL_FAULT: return {31'd0, fault};
            SEL_RETRY: return {24'd0, retry_cnt};
            SEL_LSYNC: return {30'd0, lock_sync};
            default:   return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%0d expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    // Edges until the probed output equals val; stops at BOUND so a stuck DUT yields a mismatching count.
    task automatic wait_for(input int sel, input logic [31:0] val, output int n);
        n = 0;
        while (probe(sel) !== val && n < BOUND) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n1;
        int n2;
        rst_n   = 1'b0;
        restart = 1'b0;
        lock_in = 2'b00;
        repeat (3) step();

        // Reset values
        push("rst_pll", 32'd1);   chk(probe(SEL_PLL));
        push("rst_dom", 32'd7);   chk(probe(SEL_DOM));
        push("rst_ready", 32'd0); chk(probe(SEL_READY));
        push("rst_fault", 32'd0); chk(probe(SEL_FAULT));
        push("rst_retry", 32'd0); chk(probe(SEL_RETRY));
        push("rst_lsync", 32'd0); chk(probe(SEL_LSYNC));

        // Nominal bring-up
        push("pll_pulse", 32'd4);
        rst_n = 1'b1;
        wait_for(SEL_PLL, 32'd0, n1); chk(n1);
        repeat (6) step();
        push("lsync_lat", 32'd2);
        push("dom0_lat", 32'd11);
        lock_in = 2'b11;
        wait_for(SEL_LSYNC, 32'd3, n1); chk(n1);
        wait_for(SEL_DOM, 32'd6, n2);   chk(n1 + n2);
        push("stagger1", 32'd2);
        wait_for(SEL_DOM, 32'd4, n1); chk(n1);
        push("ready_early", 32'd0); chk(probe(SEL_READY));
        push("stagger2", 32'd2);
        wait_for(SEL_DOM, 32'd0, n1); chk(n1);
        push("ready_run", 32'd1);  chk(probe(SEL_READY));
        push("retry_run", 32'd0);  chk(probe(SEL_RETRY));

        // Lock loss in RUN, then re-lock
        push("loss_lat", 32'd3);
        lock_in = 2'b01;
        wait_for(SEL_DOM, 32'd7, n1); chk(n1);
        push("loss_ready", 32'd0); chk(probe(SEL_READY));
        push("loss_pll", 32'd1);   chk(probe(SEL_PLL));
        push("loss_pulse", 32'd4);
        wait_for(SEL_PLL, 32'd0, n1); chk(n1);
        push("loss_retry", 32'd0); chk(probe(SEL_RETRY));
        push("relock_ready", 32'd15);
        lock_in = 2'b11;
        wait_for(SEL_READY, 32'd1, n1); chk(n1);

        // Restart from RUN, then lock loss mid-RELEASE
        push("rs_dom", 32'd7);
        push("rs_pll", 32'd1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk(probe(SEL_DOM));
        chk(probe(SEL_PLL));
        push("rs_dom0", 32'd13);
        wait_for(SEL_DOM, 32'd6, n1); chk(n1);
        push("mid_loss", 32'd3);
        lock_in = 2'b10;
        wait_for(SEL_DOM, 32'd7, n1); chk(n1);
        lock_in = 2'b11;
        push("mid_hold", 32'd7);
        push("mid_ready", 32'd0);
        step();
        chk(probe(SEL_DOM));
        chk(probe(SEL_READY));

        // One-cycle glitch while qualifying locks restarts the stable window
        push("g_pulse", 32'd3);
        wait_for(SEL_PLL, 32'd0, n1); chk(n1);
        repeat (6) step();
        lock_in = 2'b10;
        step();
        lock_in = 2'b11;
        push("glitch_rel", 32'd18);
        wait_for(SEL_DOM, 32'd6, n1); chk(n1 + 32'd7);
        push("glitch_retry", 32'd0); chk(probe(SEL_RETRY));
        push("glitch_ready", 32'd4);
        wait_for(SEL_READY, 32'd1, n1); chk(n1);

        // Missing lock: retries, then sticky fault
        push("miss_loss", 32'd3);
        lock_in = 2'b01;
        wait_for(SEL_DOM, 32'd7, n1); chk(n1);
        for (int r = 1; r <= 2; r++) begin
            push("miss_pulse", 32'd4);
            wait_for(SEL_PLL, 32'd0, n1); chk(n1);
            push("miss_timeout", 32'd32);
            wait_for(SEL_PLL, 32'd1, n1); chk(n1);
            push("miss_retry", 32'(r));
            chk(probe(SEL_RETRY));
        end
        push("miss_pulse3", 32'd4);
        wait_for(SEL_PLL, 32'd0, n1); chk(n1);
        push("fault_lat", 32'd32);
        wait_for(SEL_FAULT, 32'd1, n1); chk(n1);
        push("fault_retry", 32'd2); chk(probe(SEL_RETRY));
        push("fault_pll", 32'd1);   chk(probe(SEL_PLL));
        push("fault_dom", 32'd7);   chk(probe(SEL_DOM));
        repeat (10) step();
        push("fault_sticky", 32'd1); chk(probe(SEL_FAULT));
        push("clr_fault", 32'd0);
        push("clr_retry", 32'd0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk(probe(SEL_FAULT));
        chk(probe(SEL_RETRY));

        // Async reset mid-RUN
        lock_in = 2'b11;
        push("rs_ready", 32'd17);
        wait_for(SEL_READY, 32'd1, n1); chk(n1);
        #3;
        rst_n = 1'b0;
        #1;
        push("ar_pll", 32'd1);   chk(probe(SEL_PLL));
        push("ar_dom", 32'd7);   chk(probe(SEL_DOM));
        push("ar_ready", 32'd0); chk(probe(SEL_READY));
        push("ar_lsync", 32'd0); chk(probe(SEL_LSYNC));
        step();
        rst_n = 1'b1;
        push("ar_ready_again", 32'd17);
        wait_for(SEL_READY, 32'd1, n1); chk(n1);

        // restart colliding with lock loss, then with a lock timeout
        lock_in = 2'b01;
        step();
        step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        push("col_retry", 32'd0); chk(probe(SEL_RETRY));
        push("col_dom", 32'd7);   chk(probe(SEL_DOM));
        push("col_pll", 32'd1);   chk(probe(SEL_PLL));
        push("col_pulse", 32'd4);
        wait_for(SEL_PLL, 32'd0, n1); chk(n1);
        repeat (31) step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        push("to_col_retry", 32'd0); chk(probe(SEL_RETRY));
        push("to_col_fault", 32'd0); chk(probe(SEL_FAULT));
        push("to_col_pulse", 32'd4);
        wait_for(SEL_PLL, 32'd0, n1); chk(n1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
